seg7_scan_controller: RTL and testbench

//  Time-multiplexes the board's 4-digit seven-segment display between two requesters: source A
//  (16-bit CPU output word, hex-decoded in-block) and source B (pre-decoded 4x7 segment patterns,
//  e.g. opcode mnemonic). Each source hands over a frame via valid/ready; the selected frame is

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_scan_timer.sv | 47 ++++
 rtl/seg7_scan_controller.sv | 103 ++++++++++
 tb/tb_seg7_scan_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the seven-segment scan block.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  // Active-low segments {g,f,e,d,c,b,a}, bit0 = a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Dwell prescaler and digit index counter; flags blanking and the frame boundary.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  output digit_idx_t idx_o,
  output logic       blank_o,
  output logic       frame_boundary_o
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  digit_idx_t    idx_q, idx_d;
  logic          wrap;

  assign wrap             = (32'(presc_q) == CLK_DIV - 1);
  assign blank_o          = (32'(presc_q) < BLANK_CYCLES);
  assign idx_o            = idx_q;
  assign frame_boundary_o = wrap && (idx_q == 2'd3);

  // Next prescaler value and digit advance on prescaler wrap.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// Two-source seven-segment scan controller: per-source holding registers, frame-boundary
// commit into the display buffer, and registered anode/cathode drive.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] src_a_data,
  input  logic        src_a_valid,
  output logic        src_a_ready,
  input  logic [27:0] src_b_segs,
  input  logic        src_b_valid,
  output logic        src_b_ready,
  input  logic        sel_b,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  digit_idx_t       idx;
  logic             blank, boundary;

  logic             held_a_q, held_a_d, held_b_q, held_b_d;
  logic [15:0]      hold_a_q, hold_a_d;
  logic [27:0]      hold_b_q, hold_b_d;
  logic [3:0][6:0]  buf_q, buf_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             acc_a, acc_b, commit_a, commit_b;

  seg7_scan_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk              (clk),
    .reset            (reset),
    .idx_o            (idx),
    .blank_o          (blank),
    .frame_boundary_o (boundary)
  );

  assign src_a_ready = ~held_a_q & ~reset;
  assign src_b_ready = ~held_b_q & ~reset;
  assign acc_a       = src_a_valid & src_a_ready;
  assign acc_b       = src_b_valid & src_b_ready;
  assign commit_a    = boundary & ~sel_b & held_a_q;
  assign commit_b    = boundary &  sel_b & held_b_q;
  assign frame_tick  = boundary & ~reset;
  assign seg         = seg_q;
  assign an          = an_q;

  // Handshake capture, boundary commit and next output drive.
  always_comb begin
    held_a_d = held_a_q;
    held_b_d = held_b_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    buf_d    = buf_q;
    // Clear-on-commit precedes set-on-accept so a same-cycle accept leaves the flag set.
    if (commit_a) held_a_d = 1'b0;
    if (commit_b) held_b_d = 1'b0;
    if (acc_a) begin
      held_a_d = 1'b1;
      hold_a_d = src_a_data;
    end
    if (acc_b) begin
      held_b_d = 1'b1;
      hold_b_d = src_b_segs;
    end
    for (int unsigned k = 0; k < 4; k++) begin
      if (commit_a)      buf_d[k] = hex_to_seg(hold_a_q[4*k +: 4]);
      else if (commit_b) buf_d[k] = hold_b_q[7*k +: 7];
    end
    seg_d = buf_q[idx];
    an_d  = blank ? 4'hF : ~((4'b0001 << idx) & digit_en);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_a_q <= 1'b0;
      held_b_q <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      buf_q    <= {4{SEG_BLANK}};
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      held_a_q <= held_a_d;
      held_b_q <= held_b_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      buf_q    <= buf_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with CLK_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] src_a_data;
  logic        src_a_valid;
  logic        src_a_ready;
  logic [27:0] src_b_segs;
  logic        src_b_valid;
  logic        src_b_ready;
  logic        sel_b;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  int ph    = 0;

  logic [3:0][6:0] exp_buf;
  logic [3:0]      exp_en;

  seg7_scan_controller #(
    .CLK_DIV      (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_a_data  (src_a_data),
    .src_a_valid (src_a_valid),
    .src_a_ready (src_a_ready),
    .src_b_segs  (src_b_segs),
    .src_b_valid (src_b_valid),
    .src_b_ready (src_b_ready),
    .sel_b       (sel_b),
    .digit_en    (digit_en),
    .seg         (seg),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Cycles since reset release: prescaler = ph%8, idx = (ph/8)%4.
  always @(posedge clk) begin
    if (reset) ph <= 0;
    else       ph <= ph + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step to the next frame-boundary state, checking an/seg/frame_tick every cycle.
  task automatic run_frame(input string name);
    int n = 0;
    int prev, p, i;
    logic [3:0] ea;
    logic [6:0] es;
    logic       et;
    do begin
      step();
      n++;
      prev = ph - 1;
      p    = prev % 8;
      i    = (prev / 8) % 4;
      ea   = (p < 2) ? 4'hF : ~((4'b0001 << i) & exp_en);
      es   = exp_buf[i];
      et   = ((ph % 32) == 31);
      total++;
      if (an !== ea) begin
        bad++;
        $display("FAIL %s an ph=%0d got=%h want=%h", name, ph, an, ea);
      end
      total++;
      if (seg !== es) begin
        bad++;
        $display("FAIL %s seg ph=%0d got=%h want=%h", name, ph, seg, es);
      end
      total++;
      if (frame_tick !== et) begin
        bad++;
        $display("FAIL %s frame_tick ph=%0d got=%b want=%b", name, ph, frame_tick, et);
      end
    end while (((ph % 32) != 31) && (n < 40));
    total++;
    if ((ph % 32) != 31) begin
      bad++;
      $display("FAIL %s boundary_timeout ph=%0d", name, ph);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    total++;
    if (an !== 4'hF) begin bad++; $display("FAIL reset an got=%h want=F", an); end
    total++;
    if (seg !== 7'h7F) begin bad++; $display("FAIL reset seg got=%h want=7F", seg); end
    total++;
    if ({src_a_ready, src_b_ready} !== 2'b00) begin
      bad++; $display("FAIL reset ready got=%b want=00", {src_a_ready, src_b_ready});
    end
    total++;
    if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset frame_tick got=%b want=0", frame_tick); end
    reset = 1'b0;
    #1;
    total++;
    if ({src_a_ready, src_b_ready} !== 2'b11) begin
      bad++; $display("FAIL release ready got=%b want=11", {src_a_ready, src_b_ready});
    end
    run_frame("scan_blank");
  endtask

  task automatic test_src_a();
    step();
    src_a_data  = 16'h12AF;
    src_a_valid = 1'b1;
    step();
    total++;
    if (src_a_ready !== 1'b0) begin bad++; $display("FAIL a_accept ready got=%b want=0", src_a_ready); end
    src_a_valid = 1'b0;
    run_frame("a_pending");
    step();
    exp_buf = {7'h79, 7'h24, 7'h08, 7'h0E};
    total++;
    if (src_a_ready !== 1'b1) begin bad++; $display("FAIL a_commit ready got=%b want=1", src_a_ready); end
    run_frame("a_shown");
  endtask

  task automatic test_blanking();
    step();
    digit_en = 4'b0101;
    exp_en   = 4'b0101;
    run_frame("digit_en_0101");
    digit_en = 4'hF;
    exp_en   = 4'hF;
  endtask

  task automatic test_src_b();
    step();
    src_b_segs  = {7'h3C, 7'h55, 7'h2A, 7'h11};
    src_b_valid = 1'b1;
    step();
    total++;
    if (src_b_ready !== 1'b0) begin bad++; $display("FAIL b_accept ready got=%b want=0", src_b_ready); end
    src_b_valid = 1'b0;
    run_frame("b_unselected");
    step();
    total++;
    if (src_b_ready !== 1'b0) begin bad++; $display("FAIL b_retained ready got=%b want=0", src_b_ready); end
    sel_b = 1'b1;
    run_frame("b_sel_wait");
    step();
    exp_buf = {7'h3C, 7'h55, 7'h2A, 7'h11};
    total++;
    if (src_b_ready !== 1'b1) begin bad++; $display("FAIL b_commit ready got=%b want=1", src_b_ready); end
    run_frame("b_shown");
  endtask

  task automatic test_back_to_back();
    step();
    sel_b       = 1'b0;
    src_a_data  = 16'h3456;
    src_a_valid = 1'b1;
    step();
    total++;
    if (src_a_ready !== 1'b0) begin bad++; $display("FAIL b2b_w1 ready got=%b want=0", src_a_ready); end
    src_a_data = 16'h789B;
    run_frame("b2b_hold_w1");
    total++;
    if (src_a_ready !== 1'b0) begin bad++; $display("FAIL b2b_boundary ready got=%b want=0", src_a_ready); end
    step();
    exp_buf = {7'h30, 7'h19, 7'h12, 7'h02};
    total++;
    if (src_a_ready !== 1'b1) begin bad++; $display("FAIL b2b_commit ready got=%b want=1", src_a_ready); end
    step();
    total++;
    if (src_a_ready !== 1'b0) begin bad++; $display("FAIL b2b_w2 ready got=%b want=0", src_a_ready); end
    src_a_valid = 1'b0;
    run_frame("b2b_show_w1");
    total++;
    if (src_a_ready !== 1'b0) begin bad++; $display("FAIL b2b_w2_held ready got=%b want=0", src_a_ready); end
    step();
    exp_buf = {7'h78, 7'h00, 7'h10, 7'h03};
    total++;
    if (src_a_ready !== 1'b1) begin bad++; $display("FAIL b2b_w2_commit ready got=%b want=1", src_a_ready); end
    run_frame("b2b_show_w2");
  endtask

  task automatic test_reset_mid_frame();
    step();
    src_a_data  = 16'hCDEF;
    src_a_valid = 1'b1;
    step();
    src_a_valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    #1;
    total++;
    if (src_a_ready !== 1'b0) begin bad++; $display("FAIL midrst ready_during got=%b want=0", src_a_ready); end
    step();
    total++;
    if (an !== 4'hF) begin bad++; $display("FAIL midrst an got=%h want=F", an); end
    total++;
    if (seg !== 7'h7F) begin bad++; $display("FAIL midrst seg got=%h want=7F", seg); end
    total++;
    if (frame_tick !== 1'b0) begin bad++; $display("FAIL midrst frame_tick got=%b want=0", frame_tick); end
    reset   = 1'b0;
    exp_buf = {4{7'h7F}};
    #1;
    total++;
    if ({src_a_ready, src_b_ready} !== 2'b11) begin
      bad++; $display("FAIL midrst ready got=%b want=11", {src_a_ready, src_b_ready});
    end
    run_frame("midrst_scan");
    step();
    run_frame("midrst_discarded");
  endtask

  initial begin
    reset       = 1'b1;
    src_a_data  = '0;
    src_a_valid = 1'b0;
    src_b_segs  = '0;
    src_b_valid = 1'b0;
    sel_b       = 1'b0;
    digit_en    = 4'hF;
    exp_en      = 4'hF;
    exp_buf     = {4{7'h7F}};
    test_reset();
    test_src_a();
    test_blanking();
    test_src_b();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
